multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences a multi-cycle RV32I datapath: fetch, decode, execute, memory, writeback. It takes `opcode`/`funct3` from the instruction decoder, the branch-compare result from the ALU and a ready handshake from the shared instruction/data memory. It drives every datapath enable and mux select, and it is the only block that writes the PC, IR and register file.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: from the decoder, driven by the IR.
- `funct3` in 3: from the decoder.
- `br_taken` in 1: branch compare result, valid during EXEC.
- `addr_lo` in 2: ALU result bits [1:0] (store address), valid during MEM.
- `mem_ready` in 1: memory ack for the current request.
- `im_req` out 1: instruction read request.
- `ir_we` out 1: IR load enable.
- `dm_req` out 1: data memory request.
- `dm_we` out 4: byte write mask. Zero means read.
- `rf_we` out 1: register file write.
- `pc_we` out 1: PC write.
- `pc_sel` out 2: 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1.
- `alu_a_sel` out 1: 0 = rs1, 1 = pc.
- `alu_b_sel` out 1: 0 = rs2, 1 = imm.
- `wb_sel` out 2: 0 = ALU, 1 = memory, 2 = pc+4, 3 = imm.
- `state` out 3: current state, for debug.
- `illegal` out 1: present only with `MC_ILLEGAL_TRAP_EN`.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: `rst` high forces state to FETCH at the next edge.
  - While `rst` is high, all control outputs are 0 and `op_q`/`f3_q` are cleared.
- Control outputs are combinational from state, `op_q`, `f3_q`, `br_taken` and `mem_ready`.
- FETCH: `im_req`=1. When `mem_ready`=1: `ir_we`=1, go to DECODE. Otherwise stay.
- DECODE: latch `opcode` into `op_q` and `funct3` into `f3_q`. Go to EXEC. Later states use only the latched copies.
- EXEC: ALU selects per `op_q`:
  - R-type: a=rs1, b=rs2.
  - I-ALU, load, store, jalr: a=rs1, b=imm.
  - auipc, jal: a=pc, b=imm.
  - Branch: a=rs1, b=rs2.
- EXEC next state:
  - Load or store: go to MEM.
  - Branch: `pc_we`=1, `pc_sel` = `br_taken` ? 1 : 0, go to FETCH.
  - R, I-ALU, lui, auipc, jal, jalr: go to WB.
- MEM: `dm_req`=1.
  - Store `dm_we`: sb = 0001<<`addr_lo`; sh = 0011<<{`addr_lo[1]`,0}; sw = 1111; other `f3_q` = 0000.
  - Load: `dm_we`=0000.
  - Hold all outputs until `mem_ready`.
  - On `mem_ready`: load goes to WB. Store sets `pc_we`=1, `pc_sel`=0 and goes to FETCH.
- WB: `rf_we`=1, `pc_we`=1, then go to FETCH.
  - `wb_sel`: ALU for R/I-ALU/auipc, memory for load, pc+4 for jal/jalr, imm for lui.
  - `pc_sel`: 1 for jal, 2 for jalr, 0 otherwise.
- Unknown `op_q` in EXEC: behaviour set by the macro below.

## Timing
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first request cycle):
  - Branch: 3.
  - Store, R, I, lui, auipc, jal, jalr: 4.
  - Load: 5.
- Each cycle `mem_ready` is low in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `rst` wins over everything, including mid-MEM. A store aborted by reset must not have `dm_we`≠0 in the reset cycle.
- At most one of `pc_we`, `ir_we` and `rf_we`+`pc_we` (WB) is active per state. `pc_we` is never high two consecutive cycles.

## Configuration
- Macro: `MC_ILLEGAL_TRAP_EN`.
- Defined: an unknown `op_q` in EXEC goes to TRAP. TRAP holds all enables at 0 and `illegal`=1, and persists until `rst`. The `illegal` port exists.
- Undefined: an unknown opcode executes as a NOP: EXEC sets `pc_we`=1, `pc_sel`=0 and goes to FETCH (3 cycles). There is no TRAP state and no `illegal` port.

## Structure
- Shared package `mc_pkg` holds:
  - State enum.
  - RV32I opcode constants: 0000011, 0010011, 0100011, 1100011, 0110011, 0010111, 0110111, 1101111, 1100111.
  - `pc_sel` and `wb_sel` encodings.
  - `funct3` constants for sb/sh/sw.
- One sub-module, `store_mask_gen`: (`f3_q`, `addr_lo`) -> `dm_we`, combinational.

## Test plan
- Reset: assert `rst` for 2 cycles mid-MEM of an sw. Required: all outputs 0 and `dm_we`=0000 during reset; `state`=0 and `im_req`=1 on the first cycle after release.
- add (0110011), zero-wait memory: FETCH→DECODE→EXEC→WB. Required: `rf_we`=1 and `wb_sel`=0 in cycle 4; next FETCH in cycle 5.
- lw with `mem_ready` low 2 cycles in MEM: MEM lasts 3 cycles with `dm_req`=1 and `dm_we`=0000. Required: then WB with `wb_sel`=1; 7 cycles total.
- sb with `addr_lo`=2: `dm_we`=0100. sh with `addr_lo`=3: `dm_we`=1100. Required in both: `rf_we` never asserted.
- beq: `br_taken`=1 gives `pc_sel`=1 in EXEC; `br_taken`=0 gives `pc_sel`=0. Required: `pc_we`=1 in cycle 3 in both cases.
- Opcode 1111111: with the macro, `state`=5 and `illegal`=1 held 10 cycles. Required without the macro: `pc_we`=1, `pc_sel`=0 in cycle 3, then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg -- shared definitions for the multicycle RV32I control FSM.
//
// Contents:
//   mc_state_e   FSM state encoding (FETCH..WB, plus TRAP when
//                MC_ILLEGAL_TRAP_EN is defined)
//   OP_*         RV32I major opcodes recognised by the controller
//   PC_SEL_*     pc_sel mux encodings
//   WB_SEL_*     wb_sel mux encodings
//   F3_S*        funct3 values for sb/sh/sw
//   is_known_op  helper: opcode is one of the nine supported classes
//
// Configuration macro: MC_ILLEGAL_TRAP_EN (adds the TRAP state).
// -----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
`ifdef MC_ILLEGAL_TRAP_EN
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
`else
        ST_WB     = 3'd4
`endif
    } mc_state_e;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;  // pc + 4
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;  // pc + imm
    localparam logic [1:0] PC_SEL_JALR  = 2'd2;  // (rs1 + imm) & ~1

    // Register file write-back source
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_IMM = 2'd3;

    // Store widths
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IALU, OP_STORE, OP_BRANCH, OP_RTYPE,
            OP_AUIPC, OP_LUI, OP_JAL, OP_JALR: is_known_op = 1'b1;
            default:                           is_known_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_mask_gen.sv
// -----------------------------------------------------------------------------
// store_mask_gen -- byte-lane write mask for RV32I stores (combinational).
//
// Ports:
//   f3_i       in  3  latched funct3 of the store
//   addr_lo_i  in  2  store address bits [1:0]
//   dm_we_o    out 4  byte write mask (0000 for unsupported funct3)
//
// Misaligned halfwords are not trapped: sh uses only addr bit 1 to pick the
// half, so addr_lo=3 still selects the upper half (1100).
// -----------------------------------------------------------------------------
module store_mask_gen
    import mc_pkg::*;
(
    input  logic [2:0] f3_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] dm_we_o
);

    always_comb begin
        dm_we_o = 4'b0000;
        case (f3_i)
            F3_SB:   dm_we_o = 4'b0001 << addr_lo_i;
            F3_SH:   dm_we_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            F3_SW:   dm_we_o = 4'b1111;
            default: dm_we_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller -- control FSM for a multi-cycle RV32I datapath.
//
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH and drives every
// datapath enable / mux select. Only this block writes PC, IR and the RF.
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst        in  1  synchronous active-high reset
//   opcode     in  7  decoder opcode (from IR), latched in DECODE
//   funct3     in  3  decoder funct3, latched in DECODE
//   br_taken   in  1  branch compare result, used in EXEC
//   addr_lo    in  2  ALU result [1:0] (store address), used in MEM
//   mem_ready  in  1  memory ack, used only in FETCH and MEM
//   im_req     out 1  instruction read request
//   ir_we      out 1  IR load enable
//   dm_req     out 1  data memory request
//   dm_we      out 4  byte write mask, 0000 = read
//   rf_we      out 1  register file write
//   pc_we      out 1  PC write
//   pc_sel     out 2  0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1
//   alu_a_sel  out 1  0 rs1, 1 pc
//   alu_b_sel  out 1  0 rs2, 1 imm
//   wb_sel     out 2  0 ALU, 1 mem, 2 pc+4, 3 imm
//   state      out 3  current state (debug)
//   illegal    out 1  TRAP indicator (only with MC_ILLEGAL_TRAP_EN)
//
// Configuration macro: MC_ILLEGAL_TRAP_EN
//   defined   -> unknown opcode in EXEC enters TRAP, held until rst
//   undefined -> unknown opcode retires as a NOP from EXEC (pc <- pc+4)
//
// Outputs are combinational from state, op_q, f3_q, br_taken, mem_ready and
// are all forced to zero while rst is high, so a store interrupted by reset
// never drives a write mask in the reset cycle.
// -----------------------------------------------------------------------------
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    input  logic [1:0] addr_lo,
    input  logic       mem_ready,
    output logic       im_req,
    output logic       ir_we,
    output logic       dm_req,
    output logic [3:0] dm_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] wb_sel,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [2:0] state
);

    mc_state_e  state_q, state_d;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic [3:0] st_mask;
    logic       is_store;

    assign is_store = (op_q == OP_STORE);

    store_mask_gen u_store_mask (
        .f3_i      (f3_q),
        .addr_lo_i (addr_lo),
        .dm_we_o   (st_mask)
    );

    // State register plus the latched instruction fields. After DECODE the
    // opcode/funct3 inputs are ignored so the IR may change underneath us.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= 7'd0;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
            end
        end
    end

    // Next state and control outputs.
    always_comb begin
        state_d   = state_q;
        im_req    = 1'b0;
        ir_we     = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 4'b0000;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        wb_sel    = WB_SEL_ALU;
`ifdef MC_ILLEGAL_TRAP_EN
        illegal   = 1'b0;
`endif
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    im_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end

                ST_DECODE: state_d = ST_EXEC;

                ST_EXEC: begin
                    case (op_q)
                        OP_RTYPE: state_d = ST_WB;
                        OP_IALU, OP_JALR: begin
                            alu_b_sel = 1'b1;
                            state_d   = ST_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_b_sel = 1'b1;
                            state_d   = ST_MEM;
                        end
                        OP_AUIPC, OP_JAL: begin
                            alu_a_sel = 1'b1;
                            alu_b_sel = 1'b1;
                            state_d   = ST_WB;
                        end
                        OP_LUI: state_d = ST_WB;
                        OP_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_sel  = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                            state_d = ST_FETCH;
                        end
                        default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                            state_d = ST_TRAP;
`else
                            // unknown opcode retires as a NOP
                            pc_we   = 1'b1;
                            pc_sel  = PC_SEL_PLUS4;
                            state_d = ST_FETCH;
`endif
                        end
                    endcase
                end

                ST_MEM: begin
                    // request and mask stay stable until the memory acks
                    dm_req = 1'b1;
                    dm_we  = is_store ? st_mask : 4'b0000;
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_SEL_PLUS4;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end

                ST_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (op_q)
                        OP_LOAD:          wb_sel = WB_SEL_MEM;
                        OP_JAL, OP_JALR:  wb_sel = WB_SEL_PC4;
                        OP_LUI:           wb_sel = WB_SEL_IMM;
                        default:          wb_sel = WB_SEL_ALU;
                    endcase
                    case (op_q)
                        OP_JAL:  pc_sel = PC_SEL_IMM;
                        OP_JALR: pc_sel = PC_SEL_JALR;
                        default: pc_sel = PC_SEL_PLUS4;
                    endcase
                    state_d = ST_FETCH;
                end

`ifdef MC_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    // parked with every enable low until reset
                    illegal = 1'b1;
                    state_d = ST_TRAP;
                end
`endif

                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// Directed bench for multicycle_controller. Each task starts in a FETCH cycle
// (inputs applied 1ns after the rising edge, outputs sampled 1ns later) and
// returns in the next FETCH cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic [1:0] addr_lo;
    logic       mem_ready;
    logic       im_req, ir_we, dm_req, rf_we, pc_we, alu_a_sel, alu_b_sel;
    logic [3:0] dm_we;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int tests = 0;
    int fails = 0;

    logic [17:0] ctl_all;
    assign ctl_all = {im_req, ir_we, dm_req, dm_we, rf_we, pc_we, pc_sel,
                      alu_a_sel, alu_b_sel, wb_sel, state};

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .br_taken  (br_taken),
        .addr_lo   (addr_lo),
        .mem_ready (mem_ready),
        .im_req    (im_req),
        .ir_we     (ir_we),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .wb_sel    (wb_sel),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal   (illegal),
`endif
        .state     (state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // sw interrupted mid-MEM by a 2-cycle reset
    task automatic test_reset;
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; br_taken = 1'b0;
        addr_lo = 2'd0; mem_ready = 1'b0;
        tick; tick;
        rst = 1'b0; mem_ready = 1'b1; opcode = OP_STORE; funct3 = 3'b010; addr_lo = 2'd1;
        #1;
        tests++;
        if (state !== 3'd0 || im_req !== 1'b1 || ir_we !== 1'b1) begin
            fails++; $display("FAIL reset_first_fetch: state=%0d im_req=%b ir_we=%b, want 0/1/1", state, im_req, ir_we);
        end
        tick; mem_ready = 1'b0; #1;
        tick; #1;
        tick; #1;
        tests++;
        if (state !== 3'd3 || dm_req !== 1'b1 || dm_we !== 4'b1111) begin
            fails++; $display("FAIL sw_mem: state=%0d dm_req=%b dm_we=%b, want 3/1/1111", state, dm_req, dm_we);
        end
        rst = 1'b1; #1;
        tests++;
        if (ctl_all !== 18'd0) begin
            fails++; $display("FAIL reset_cycle1_zero: outputs=%b, want all 0", ctl_all);
        end
        tick; #1;
        tests++;
        if (ctl_all !== 18'd0) begin
            fails++; $display("FAIL reset_cycle2_zero: outputs=%b, want all 0", ctl_all);
        end
        tick; rst = 1'b0; mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0 || im_req !== 1'b1 || dm_we !== 4'b0000) begin
            fails++; $display("FAIL reset_release: state=%0d im_req=%b dm_we=%b, want 0/1/0000", state, im_req, dm_we);
        end
    endtask

    // FETCH stalls, then an I-ALU op; mem_ready wiggles outside FETCH/MEM
    task automatic test_fetch_wait;
        opcode = OP_IALU; funct3 = 3'd0; mem_ready = 1'b0; #1;
        tick; #1;
        tests++;
        if (state !== 3'd0 || ir_we !== 1'b0 || im_req !== 1'b1) begin
            fails++; $display("FAIL fetch_stall: state=%0d ir_we=%b im_req=%b, want 0/0/1", state, ir_we, im_req);
        end
        tick; mem_ready = 1'b1; #1;
        tests++;
        if (state !== 3'd0 || ir_we !== 1'b1) begin
            fails++; $display("FAIL fetch_ack: state=%0d ir_we=%b, want 0/1", state, ir_we);
        end
        tick; mem_ready = 1'b0; #1;
        tick; #1;
        tests++;
        if (state !== 3'd2 || alu_a_sel !== 1'b0 || alu_b_sel !== 1'b1 || pc_we !== 1'b0) begin
            fails++; $display("FAIL ialu_exec: state=%0d a=%b b=%b pc_we=%b, want 2/0/1/0", state, alu_a_sel, alu_b_sel, pc_we);
        end
        tick; #1;
        tests++;
        if (state !== 3'd4 || rf_we !== 1'b1 || wb_sel !== 2'd0 || pc_sel !== 2'd0) begin
            fails++; $display("FAIL ialu_wb: state=%0d rf_we=%b wb_sel=%0d pc_sel=%0d, want 4/1/0/0", state, rf_we, wb_sel, pc_sel);
        end
        tick; #1;
    endtask

    // add with zero-wait memory: 4 cycles
    task automatic test_add;
        opcode = OP_RTYPE; funct3 = 3'd0; mem_ready = 1'b1; #1;
        tick; mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd1) begin
            fails++; $display("FAIL add_decode: state=%0d, want 1", state);
        end
        tick; mem_ready = 1'b1; #1;
        tests++;
        if (state !== 3'd2 || alu_a_sel !== 1'b0 || alu_b_sel !== 1'b0) begin
            fails++; $display("FAIL add_exec: state=%0d a=%b b=%b, want 2/0/0", state, alu_a_sel, alu_b_sel);
        end
        tick; #1;
        tests++;
        if (state !== 3'd4 || rf_we !== 1'b1 || wb_sel !== 2'd0 || pc_we !== 1'b1) begin
            fails++; $display("FAIL add_wb: state=%0d rf_we=%b wb_sel=%0d pc_we=%b, want 4/1/0/1", state, rf_we, wb_sel, pc_we);
        end
        tick; mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0 || pc_we !== 1'b0) begin
            fails++; $display("FAIL add_next_fetch: state=%0d pc_we=%b, want 0/0", state, pc_we);
        end
    endtask

    // lw with mem_ready low for 2 MEM cycles: 7 cycles
    task automatic test_lw_wait;
        logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] st  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        opcode = OP_LOAD; funct3 = 3'b010;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick;
            mem_ready = (c < 7) ? rdy[c] : 1'b0;
            #1;
            tests++;
            if (state !== st[c]) begin
                fails++; $display("FAIL lw_state_c%0d: state=%0d, want %0d", c + 1, state, st[c]);
            end
            if (c >= 3 && c <= 5) begin
                tests++;
                if (dm_req !== 1'b1 || dm_we !== 4'b0000 || pc_we !== 1'b0) begin
                    fails++; $display("FAIL lw_mem_c%0d: dm_req=%b dm_we=%b pc_we=%b, want 1/0000/0", c + 1, dm_req, dm_we, pc_we);
                end
            end
            if (c == 6) begin
                tests++;
                if (rf_we !== 1'b1 || wb_sel !== 2'd1) begin
                    fails++; $display("FAIL lw_wb: rf_we=%b wb_sel=%0d, want 1/1", rf_we, wb_sel);
                end
            end
        end
    endtask

    // stores: one wait cycle in MEM, mask held, no RF write
    task automatic test_store;
        logic [2:0] f3 [5] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b011};
        logic [1:0] al [5] = '{2'd2,   2'd3,   2'd3,   2'd1,   2'd0};
        logic [3:0] ex [5] = '{4'b0100, 4'b1100, 4'b1000, 4'b1111, 4'b0000};
        logic rf_seen;
        for (int i = 0; i < 5; i++) begin
            rf_seen = 1'b0;
            opcode = OP_STORE; funct3 = f3[i]; addr_lo = al[i]; mem_ready = 1'b1; #1;
            rf_seen |= rf_we;
            tick; mem_ready = 1'b0; #1; rf_seen |= rf_we;
            tick; #1; rf_seen |= rf_we;
            tick; #1; rf_seen |= rf_we;
            tests++;
            if (state !== 3'd3 || dm_we !== ex[i] || pc_we !== 1'b0) begin
                fails++; $display("FAIL store%0d_mem_wait: state=%0d dm_we=%b pc_we=%b, want 3/%b/0", i, state, dm_we, pc_we, ex[i]);
            end
            tick; mem_ready = 1'b1; #1; rf_seen |= rf_we;
            tests++;
            if (dm_we !== ex[i] || pc_we !== 1'b1 || pc_sel !== 2'd0) begin
                fails++; $display("FAIL store%0d_mem_ack: dm_we=%b pc_we=%b pc_sel=%0d, want %b/1/0", i, dm_we, pc_we, pc_sel, ex[i]);
            end
            tick; mem_ready = 1'b0; #1; rf_seen |= rf_we;
            tests++;
            if (state !== 3'd0 || rf_seen !== 1'b0) begin
                fails++; $display("FAIL store%0d_end: state=%0d rf_we_seen=%b, want 0/0", i, state, rf_seen);
            end
        end
    endtask

    // beq taken / not taken: 3 cycles
    task automatic test_branch;
        for (int t = 1; t >= 0; t--) begin
            opcode = OP_BRANCH; funct3 = 3'b000; mem_ready = 1'b1; br_taken = ~t[0]; #1;
            tick; #1;
            tick; br_taken = t[0]; #1;
            tests++;
            if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== {1'b0, t[0]} || alu_a_sel !== 1'b0 || alu_b_sel !== 1'b0) begin
                fails++; $display("FAIL beq_t%0d_exec: state=%0d pc_we=%b pc_sel=%0d a=%b b=%b, want 2/1/%0d/0/0", t, state, pc_we, pc_sel, alu_a_sel, alu_b_sel, t);
            end
            tick; br_taken = ~t[0]; mem_ready = 1'b0; #1;
            tests++;
            if (state !== 3'd0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
                fails++; $display("FAIL beq_t%0d_next: state=%0d pc_we=%b rf_we=%b, want 0/0/0", t, state, pc_we, rf_we);
            end
        end
    endtask

    // jal / jalr / lui / auipc: EXEC selects and WB sources
    task automatic test_jumps_upper;
        logic [6:0] op  [4] = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        logic       ea  [4] = '{1'b1,   1'b0,    1'b0,   1'b1};
        logic       eb  [4] = '{1'b1,   1'b1,    1'b0,   1'b1};
        logic       chk [4] = '{1'b1,   1'b1,    1'b0,   1'b1};
        logic [1:0] ew  [4] = '{2'd2,   2'd2,    2'd3,   2'd0};
        logic [1:0] ep  [4] = '{2'd1,   2'd2,    2'd0,   2'd0};
        for (int i = 0; i < 4; i++) begin
            opcode = op[i]; funct3 = 3'd0; mem_ready = 1'b1; #1;
            tick; #1;
            tick; #1;
            if (chk[i]) begin
                tests++;
                if (alu_a_sel !== ea[i] || alu_b_sel !== eb[i] || pc_we !== 1'b0) begin
                    fails++; $display("FAIL op%b_exec: a=%b b=%b pc_we=%b, want %b/%b/0", op[i], alu_a_sel, alu_b_sel, pc_we, ea[i], eb[i]);
                end
            end
            tick; #1;
            tests++;
            if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1 || wb_sel !== ew[i] || pc_sel !== ep[i]) begin
                fails++; $display("FAIL op%b_wb: state=%0d rf_we=%b pc_we=%b wb_sel=%0d pc_sel=%0d, want 4/1/1/%0d/%0d", op[i], state, rf_we, pc_we, wb_sel, pc_sel, ew[i], ep[i]);
            end
            tick; mem_ready = 1'b0; #1;
        end
    endtask

    // unknown opcode 1111111
    task automatic test_illegal;
        opcode = OP_BAD; funct3 = 3'd0; mem_ready = 1'b1; #1;
        tick; #1;
        tick; #1;
`ifdef MC_ILLEGAL_TRAP_EN
        tests++;
        if (state !== 3'd2 || pc_we !== 1'b0) begin
            fails++; $display("FAIL bad_exec: state=%0d pc_we=%b, want 2/0", state, pc_we);
        end
        for (int c = 0; c < 10; c++) begin
            tick; #1;
            tests++;
            if (state !== 3'd5 || illegal !== 1'b1 || {im_req, ir_we, dm_req, dm_we, rf_we, pc_we} !== 9'd0) begin
                fails++; $display("FAIL trap_hold_c%0d: state=%0d illegal=%b enables=%b, want 5/1/0", c, state, illegal, {im_req, ir_we, dm_req, dm_we, rf_we, pc_we});
            end
        end
        rst = 1'b1; tick; rst = 1'b0; mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0 || illegal !== 1'b0) begin
            fails++; $display("FAIL trap_exit: state=%0d illegal=%b, want 0/0", state, illegal);
        end
`else
        tests++;
        if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== 2'd0 || rf_we !== 1'b0) begin
            fails++; $display("FAIL bad_nop_exec: state=%0d pc_we=%b pc_sel=%0d rf_we=%b, want 2/1/0/0", state, pc_we, pc_sel, rf_we);
        end
        tick; mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0 || pc_we !== 1'b0) begin
            fails++; $display("FAIL bad_nop_next: state=%0d pc_we=%b, want 0/0", state, pc_we);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_fetch_wait;
        test_add;
        test_lw_wait;
        test_store;
        test_branch;
        test_jumps_upper;
        test_illegal;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
